// File: rtl/score4_pkg.sv
// Shared constants for the score4 input path: button indices, default timing
// and the fixed-priority grant used when several press pulses coincide.
package score4_pkg;

   localparam int NUM_BTNS = 3;

   localparam int BTN_LEFT  = 0;
   localparam int BTN_RIGHT = 1;
   localparam int BTN_PUT   = 2;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_DELAY    = 25_000_000;
   localparam int DEF_REPEAT_PERIOD   = 12_500_000;

   // Fixed priority put > right > left; losers are dropped rather than queued.
   function automatic logic [NUM_BTNS-1:0] arbitrate(input logic [NUM_BTNS-1:0] req);
      logic [NUM_BTNS-1:0] gnt;
      gnt = '0;
      if (req[BTN_PUT]) begin
         gnt[BTN_PUT] = 1'b1;
      end else if (req[BTN_RIGHT]) begin
         gnt[BTN_RIGHT] = 1'b1;
      end else if (req[BTN_LEFT]) begin
         gnt[BTN_LEFT] = 1'b1;
      end
      return gnt;
   endfunction

endpackage : score4_pkg

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stability counter that accepts a new
// level after DEBOUNCE_CYCLES agreeing samples, and a rising-edge strobe.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q;
   logic             sync_q;
   logic             level_q;
   logic             level_d;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      // NOTE: defaults first so every path assigns both signals and no latch is inferred.
      level_d = level_q;
      cnt_d   = '0;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: non-blocking assignments so each flop samples the pre-edge value of the previous stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         meta_q  <= raw_i;
         sync_q  <= meta_q;
         level_q <= level_d;
         prev_q  <= level_q;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = level_q & ~prev_q;

endmodule : btn_debounce

// File: rtl/btn_conditioner.sv
// Conditions the three game buttons into debounced levels and one-hot press pulses.
// Optional auto-repeat for left/right is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_conditioner
   import score4_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       left_raw,
   input  logic       right_raw,
   input  logic       put_raw,
   output logic       left,
   output logic       right,
   output logic       put,
   output logic [2:0] held
);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
      $error("btn_conditioner: timing parameters must be at least 2");
   end

   logic [NUM_BTNS-1:0] raw_w;
   logic [NUM_BTNS-1:0] level_w;
   logic [NUM_BTNS-1:0] rise_w;
   logic [NUM_BTNS-1:0] req_w;
   logic [NUM_BTNS-1:0] pulse_q;

   assign raw_w[BTN_LEFT]  = left_raw;
   assign raw_w[BTN_RIGHT] = right_raw;
   assign raw_w[BTN_PUT]   = put_raw;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .raw_i  (raw_w[i]),
         .level_o(level_w[i]),
         .rise_o (rise_w[i])
      );
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam int NUM_RPT = 2;
   localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TMR_W   = $clog2(TMR_MAX);
   localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

   logic [NUM_RPT-1:0]            rpt_active_q;
   logic [NUM_RPT-1:0]            rpt_active_d;
   logic [NUM_RPT-1:0]            rpt_phase_q;
   logic [NUM_RPT-1:0]            rpt_phase_d;
   logic [NUM_RPT-1:0][TMR_W-1:0] rpt_tmr_q;
   logic [NUM_RPT-1:0][TMR_W-1:0] rpt_tmr_d;
   logic [NUM_RPT-1:0]            rpt_req_w;

   // Timers run from the press pulse regardless of arbitration outcome, so a
   // suppressed repeat never shifts the schedule; phase 0 waits the initial delay.
   always_comb begin
      rpt_active_d = rpt_active_q;
      rpt_phase_d  = rpt_phase_q;
      rpt_tmr_d    = rpt_tmr_q;
      rpt_req_w    = '0;
      for (int i = 0; i < NUM_RPT; i++) begin
         if (!level_w[i]) begin
            rpt_active_d[i] = 1'b0;
            rpt_phase_d[i]  = 1'b0;
            rpt_tmr_d[i]    = '0;
         end else if (rise_w[i]) begin
            rpt_active_d[i] = 1'b1;
            rpt_phase_d[i]  = 1'b0;
            rpt_tmr_d[i]    = '0;
         end else if (rpt_active_q[i]) begin
            if (rpt_tmr_q[i] == (rpt_phase_q[i] ? PER_LAST : DLY_LAST)) begin
               rpt_req_w[i]   = 1'b1;
               rpt_phase_d[i] = 1'b1;
               rpt_tmr_d[i]   = '0;
            end else begin
               rpt_tmr_d[i] = rpt_tmr_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rpt_active_q <= '0;
         rpt_phase_q  <= '0;
         rpt_tmr_q    <= '0;
      end else begin
         rpt_active_q <= rpt_active_d;
         rpt_phase_q  <= rpt_phase_d;
         rpt_tmr_q    <= rpt_tmr_d;
      end
   end

   assign req_w[BTN_LEFT]  = rise_w[BTN_LEFT]  | rpt_req_w[BTN_LEFT];
   assign req_w[BTN_RIGHT] = rise_w[BTN_RIGHT] | rpt_req_w[BTN_RIGHT];
   assign req_w[BTN_PUT]   = rise_w[BTN_PUT];
`else
   assign req_w = rise_w;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pulse_q <= '0;
      end else begin
         pulse_q <= arbitrate(req_w);
      end
   end

   assign left  = pulse_q[BTN_LEFT];
   assign right = pulse_q[BTN_RIGHT];
   assign put   = pulse_q[BTN_PUT];
   assign held  = level_w;

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5; expectations follow BTN_AUTO_REPEAT_EN when it is defined.
`timescale 1ns/1ps
module tb_btn_conditioner;

   localparam int DEB = 4;
   localparam int DLY = 10;
   localparam int PER = 5;

   logic       clk       = 1'b0;
   logic       rst       = 1'b0;
   logic       left_raw  = 1'b0;
   logic       right_raw = 1'b0;
   logic       put_raw   = 1'b0;
   logic       left;
   logic       right;
   logic       put;
   logic [2:0] held;
   logic [2:0] exp_p;

   int n_cmp = 0;
   int n_err = 0;

   btn_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (DLY),
      .REPEAT_PERIOD  (PER)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .left_raw (left_raw),
      .right_raw(right_raw),
      .put_raw  (put_raw),
      .left     (left),
      .right    (right),
      .put      (put),
      .held     (held)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input int e, input logic [2:0] obs, input logic [2:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
      end
   endtask

   // Repeat pulse expected after edge e for a press pulse at edge 'press' whose
   // debounced level falls at edge 'fall'.
   function automatic bit rpt(input int e, input int press, input int fall);
      bit en;
      int d;
`ifdef BTN_AUTO_REPEAT_EN
      en = 1'b1;
`else
      en = 1'b0;
`endif
      d = e - press;
      return en && (e <= fall) && (d == DLY || (d > DLY && ((d - DLY) % PER) == 0));
   endfunction

   task automatic settle();
      left_raw  = 1'b0;
      right_raw = 1'b0;
      put_raw   = 1'b0;
      repeat (6) tick();
   endtask

   initial begin
      // Reset holds everything at zero even with buttons pressed.
      left_raw  = 1'b1;
      right_raw = 1'b1;
      put_raw   = 1'b1;
      repeat (3) tick();
      check("reset_pulse", 0, {put, right, left}, 3'b000);
      check("reset_held", 0, held, 3'b000);
      left_raw  = 1'b0;
      right_raw = 1'b0;
      put_raw   = 1'b0;
      rst       = 1'b1;
      repeat (3) tick();
      check("idle_pulse", 0, {put, right, left}, 3'b000);
      check("idle_held", 0, held, 3'b000);

      // Single right press held 30 cycles.
      for (int e = 0; e < 38; e++) begin
         right_raw = (e < 30);
         tick();
         exp_p    = 3'b000;
         exp_p[1] = (e == 6) || rpt(e, 6, 35);
         check("right_pulse", e, {put, right, left}, exp_p);
         check("right_held", e, held, {1'b0, (e >= 5 && e < 35), 1'b0});
      end
      settle();

      // Bouncing put: 1,0,1,0 in pairs, final rise at edge 8.
      for (int e = 0; e < 33; e++) begin
         put_raw = (e < 8) ? ((e / 2) % 2 == 0) : (e < 25);
         tick();
         exp_p    = 3'b000;
         exp_p[2] = (e == 14);
         check("bounce_pulse", e, {put, right, left}, exp_p);
         check("bounce_held", e, held, {(e >= 13 && e < 30), 2'b00});
      end
      settle();

      // Left and put together: put wins, left press dropped.
      for (int e = 0; e < 21; e++) begin
         left_raw = (e < 13);
         put_raw  = (e < 13);
         tick();
         exp_p    = 3'b000;
         exp_p[2] = (e == 6);
         exp_p[0] = rpt(e, 6, 18);
         check("prio_pulse", e, {put, right, left}, exp_p);
         check("prio_held", e, held, (e >= 5 && e < 18) ? 3'b101 : 3'b000);
      end
      settle();

      // Long left hold: one pulse, or repeats when auto-repeat is built in.
      for (int e = 0; e < 48; e++) begin
         left_raw = (e < 40);
         tick();
         exp_p    = 3'b000;
         exp_p[0] = (e == 6) || rpt(e, 6, 45);
         check("hold_pulse", e, {put, right, left}, exp_p);
         check("hold_held", e, held, {2'b00, (e >= 5 && e < 45)});
      end
      settle();

      // Reset during a right press; button still held on release at edge 8.
      for (int e = 0; e < 29; e++) begin
         if (e == 4) rst = 1'b0;
         if (e == 8) rst = 1'b1;
         right_raw = (e < 21);
         tick();
         exp_p    = 3'b000;
         exp_p[1] = (e == 14) || rpt(e, 14, 26);
         check("rst_pulse", e, {put, right, left}, exp_p);
         check("rst_held", e, held, {1'b0, (e >= 13 && e < 26), 1'b0});
      end
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_btn_conditioner

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to accept a level change (min 2).
REQ-002 Parameter REPEAT_DELAY, 25000000, cycles from a press pulse to the first auto-repeat pulse (min 2).
REQ-003 Parameter REPEAT_PERIOD, 12500000, cycles between subsequent auto-repeat pulses (min 2).
REQ-004 Port clk, input, 1, single clock for all state.
REQ-005 Port rst, input, 1, reset; asynchronous, active-low (asserted when 0).
REQ-006 Port left_raw, input, 1, unsynchronized left button.
REQ-007 Port right_raw, input, 1, unsynchronized right button.
REQ-008 Port put_raw, input, 1, unsynchronized put button.
REQ-009 Port left, output, 1, one-cycle press pulse for the game FSMs.
REQ-010 Port right, output, 1, one-cycle press pulse.
REQ-011 Port put, output, 1, one-cycle press pulse.
REQ-012 Port held, output, 3, debounced levels {put,right,left}.

Function
REQ-013 Each raw input SHALL pass a 2-flop synchronizer before any other logic.
REQ-014 Per channel: counter increments each cycle synchronized value != debounced level, clears to 0 when equal.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and values still differ, the level SHALL take the synchronized value and the counter SHALL clear.
REQ-016 Any glitch back to the current level before acceptance SHALL clear the counter; no pulse.
REQ-017 A 0->1 debounced-level transition SHALL produce a registered pulse exactly one cycle wide, one cycle after the level change.
REQ-018 Latency: raw held high from sampling edge 0 -> pulse high after edge DEBOUNCE_CYCLES+2, low after the next edge.
REQ-019 1->0 transitions SHALL produce no pulse; release is debounced identically.
REQ-020 At most one of left/right/put SHALL be high in any cycle; priority put > right > left; losing pulses are dropped, not queued.
REQ-021 A button held continuously SHALL produce exactly one pulse (without REQ-026 feature).
REQ-022 held SHALL equal the three debounced levels, unaffected by priority arbitration.

Reset
REQ-023 While rst is 0, synchronizers, levels, counters, repeat timers and all outputs SHALL be 0.
REQ-024 Reset asserted mid-debounce or mid-repeat SHALL abandon the operation; no pulse emitted within or on exit from reset.
REQ-025 A button held through reset release SHALL be treated as a new press: pulse after edge DEBOUNCE_CYCLES+2 counted from the first edge after release.

Configuration
REQ-026 Macro BTN_AUTO_REPEAT_EN defined: left/right held high emit repeat pulses REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles until the debounced level falls; put never repeats.
REQ-027 Repeat timer SHALL clear on debounced release; a suppressed (arbitration-lost) repeat pulse SHALL not shift the schedule.
REQ-028 Macro undefined: no repeat timers synthesized; behaviour per REQ-021.

Structure
REQ-029 Shared package score4_pkg SHALL hold button index constants (BTN_LEFT=0, BTN_RIGHT=1, BTN_PUT=2) and default timing constants.
REQ-030 Sub-module btn_debounce (synchronizer + debounce counter + edge pulse) SHALL be instantiated three times; arbitration and repeat logic live in btn_conditioner.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-031 right_raw 0->1 sampled at edge 0, held 30 cycles -> right=1 only in the cycle after edge 6; held[1]=1 from edge 5; no other pulse (macro off).
REQ-032 put_raw toggles 1,0,1,0 every 2 cycles then stays high -> no pulse during bounce; single put pulse after edge DEBOUNCE_CYCLES+2 counted from the final rise.
REQ-033 left_raw and put_raw rise on same edge -> put pulses, left suppressed; held=3'b101.
REQ-034 Macro on, left_raw held 40 cycles -> left pulses after edges 6, 16, 21, 26, 31, 36, 41 (timer schedule per REQ-026; last pulse fits before debounced release).
REQ-035 rst driven 0 at edge 4 of a right press, released at edge 8 with button held -> no pulse before edge 8; right pulse after edge 14.
